// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the processor test harness: instruction opcodes and sequencer states.
package Definitions;

   typedef enum logic [3:0] {
      OP_NOP    = 4'h0,
      OP_ADD    = 4'h1,
      OP_SUB    = 4'h2,
      OP_LOAD   = 4'h3,
      OP_STORE  = 4'h4,
      OP_BRANCH = 4'h5,
      OP_HALT   = 4'hF
   } opcode_t;

   typedef enum logic [2:0] {
      IDLE,
      DUT_RST,
      START,
      RUN,
      ACKED,
      FINISH
   } seq_state_t;

   // A program count of zero still runs one program.
   function automatic logic [1:0] eff_num_progs(input logic [1:0] num);
      return (num == 2'd0) ? 2'd1 : num;
   endfunction

endpackage

// File: rtl/prog_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and active-low synchronous reset.
// CountNext exposes the value the counter takes at the coming edge.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Clear,
   input  logic             Enable,
   output logic [CNT_W-1:0] Count,
   output logic [CNT_W-1:0] CountNext
);

   always_comb begin
      CountNext = Count;
      if (Enable && (Count != '1))
         CountNext = Count + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge Clk) begin
      if (!Reset || Clear)
         Count <= '0;
      else
         Count <= CountNext;
   end

endmodule

// File: rtl/prog_sequencer.sv
// Runs 1..3 programs on an attached processor, timing each RUN phase.
// Optional run-length watchdog enabled by defining SEQ_TIMEOUT_EN.
module prog_sequencer
   import Definitions::*;
#(
   parameter int          CNT_W       = 16,
   parameter int unsigned TIMEOUT_CYC = 32'hFFF0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Go,
   input  logic [1:0]       NumProgs,
   input  logic             DutAck,
   output logic             DutReset,
   output logic             DutStart,
   output logic [1:0]       ProgIdx,
   output logic             Busy,
   output logic [CNT_W-1:0] CycleCnt,
   output logic             CntValid,
   output logic             AllDone,
   output logic             TimedOut
);

   seq_state_t       state;
   logic [CNT_W-1:0] run_count;
   logic [CNT_W-1:0] run_count_next;
   logic             cnt_clear;
   logic             cnt_enable;

   assign cnt_clear  = (state == START);
   assign cnt_enable = (state == RUN);

   sat_counter #(.CNT_W(CNT_W)) u_counter (
      .Clk       (Clk),
      .Reset     (Reset),
      .Clear     (cnt_clear),
      .Enable    (cnt_enable),
      .Count     (run_count),
      .CountNext (run_count_next)
   );

`ifdef SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
   logic timed_out;
   logic timeout_hit;
   assign timeout_hit = (run_count_next == TIMEOUT_VAL);
   assign TimedOut    = timed_out;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYC;
   assign TimedOut       = 1'b0;
`endif

   // run_count_next already includes the current RUN cycle, so an Ack on the first RUN cycle reports 1.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state    <= IDLE;
         DutReset <= 1'b0;
         DutStart <= 1'b0;
         ProgIdx  <= 2'd0;
         Busy     <= 1'b0;
         CycleCnt <= '0;
         CntValid <= 1'b0;
         AllDone  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         timed_out <= 1'b0;
`endif
      end else begin
         DutReset <= 1'b0;
         DutStart <= 1'b0;
         CntValid <= 1'b0;
         case (state)
            IDLE, FINISH: begin
               if (Go) begin
                  state    <= DUT_RST;
                  DutReset <= 1'b1;
                  ProgIdx  <= 2'd0;
                  Busy     <= 1'b1;
                  AllDone  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                  timed_out <= 1'b0;
`endif
               end
            end
            DUT_RST: begin
               state    <= START;
               DutStart <= 1'b1;
            end
            START: begin
               state <= RUN;
            end
            RUN: begin
               if (DutAck) begin
                  CycleCnt <= run_count_next;
                  CntValid <= 1'b1;
                  state    <= ACKED;
               end
`ifdef SEQ_TIMEOUT_EN
               else if (timeout_hit) begin
                  timed_out <= 1'b1;
                  CycleCnt  <= TIMEOUT_VAL;
                  CntValid  <= 1'b1;
                  Busy      <= 1'b0;
                  AllDone   <= 1'b1;
                  state     <= FINISH;
               end
`endif
            end
            ACKED: begin
               if (({1'b0, ProgIdx} + 3'd1) < {1'b0, eff_num_progs(NumProgs)}) begin
                  ProgIdx  <= ProgIdx + 2'd1;
                  DutStart <= 1'b1;
                  state    <= START;
               end else begin
                  Busy    <= 1'b0;
                  AllDone <= 1'b1;
                  state   <= FINISH;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
